// File: rtl/cdb_writeback_arbiter.sv
// Common data bus writeback arbiter: four per-source holding FIFOs feeding one
// registered CDB broadcast per cycle, round-robin, with branch squash/resolve.
package cdb_pkg;
  typedef struct packed {
    logic        valid;
    logic        spec;
    logic [4:0]  rob_tag;
    logic [31:0] value;
    logic [31:0] inst;
    logic [31:0] NPC;
  } EX_WR_PACKET;
endpackage

module cdb_writeback_arbiter
  import cdb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  EX_WR_PACKET alu_packet_in,
  input  EX_WR_PACKET addr_packet_in,
  input  EX_WR_PACKET mult_packet_in,
  input  EX_WR_PACKET load_packet_in,
  input  logic        branch_determined,
  input  logic        branch_misprediction,
  output EX_WR_PACKET cdb_packet_out,
  output logic        alu_stall,
  output logic        addr_stall,
  output logic        rs_mult_exec_stall,
  output logic        load_stall,
  output logic [1:0]  grant_src
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  EX_WR_PACKET   ent_q   [4][FIFO_DEPTH];
  EX_WR_PACKET   ent_d   [4][FIFO_DEPTH];
  logic [CW-1:0] count_q [4];
  logic [CW-1:0] count_d [4];
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [1:0]    grant_q, grant_d;
  EX_WR_PACKET   cdb_q, cdb_d;

  EX_WR_PACKET   pkt_in [4];
  logic [3:0]    stall, eligible, enq;
  logic          found;
  logic [1:0]    gnt;
  logic          squash, resolve;

  assign pkt_in[0] = alu_packet_in;
  assign pkt_in[1] = addr_packet_in;
  assign pkt_in[2] = mult_packet_in;
  assign pkt_in[3] = load_packet_in;

  assign squash  = branch_misprediction;
  assign resolve = branch_determined & ~branch_misprediction;

  // Stall comes only from the registered count so sources see a stable value all cycle.
  always_comb begin
    stall    = '0;
    eligible = '0;
    enq      = '0;
    for (int i = 0; i < 4; i++) begin
      stall[i]    = (count_q[i] == CW'(FIFO_DEPTH));
      eligible[i] = (count_q[i] != '0) && !(squash && ent_q[i][0].spec);
      enq[i]      = pkt_in[i].valid && !stall[i] && !(squash && pkt_in[i].spec);
    end
  end

  always_comb begin
    found = 1'b0;
    gnt   = rr_ptr_q;
    for (int off = 0; off < 4; off++) begin
      if (!found && eligible[rr_ptr_q + 2'(off)]) begin
        found = 1'b1;
        gnt   = rr_ptr_q + 2'(off);
      end
    end
  end

  // Head sits in slot 0: survivors are packed down in order (dequeue and squash
  // both open gaps), then the incoming packet lands behind them.
  always_comb begin
    int   n;
    logic keep;
    n    = 0;
    keep = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      for (int k = 0; k < FIFO_DEPTH; k++) ent_d[i][k] = ent_q[i][k];
      for (int s = 0; s < FIFO_DEPTH; s++) begin
        keep = (s < int'(count_q[i])) && !(found && (gnt == 2'(i)) && (s == 0)) &&
               !(squash && ent_q[i][s].spec);
        if (keep) begin
          for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (k == n) begin
              ent_d[i][k]      = ent_q[i][s];
              ent_d[i][k].spec = ent_q[i][s].spec & ~resolve;
            end
          end
          n = n + 1;
        end
      end
      if (enq[i]) begin
        for (int k = 0; k < FIFO_DEPTH; k++) begin
          if (k == n) begin
            ent_d[i][k]      = pkt_in[i];
            ent_d[i][k].spec = pkt_in[i].spec & ~resolve;
          end
        end
        n = n + 1;
      end
      count_d[i] = CW'(n);
    end
  end

  always_comb begin
    cdb_d    = '0;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    if (found) begin
      cdb_d      = ent_q[gnt][0];
      cdb_d.spec = ent_q[gnt][0].spec & ~resolve;
      rr_ptr_d   = gnt + 2'd1;
      grant_d    = gnt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) count_q[i] <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cdb_q    <= '0;
    end else begin
      for (int i = 0; i < 4; i++) count_q[i] <= count_d[i];
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cdb_q    <= cdb_d;
    end
  end

  // Entry storage is qualified by count, so it needs no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < FIFO_DEPTH; k++) ent_q[i][k] <= ent_d[i][k];
  end

  assign cdb_packet_out     = cdb_q;
  assign grant_src          = grant_q;
  assign alu_stall          = stall[0];
  assign addr_stall         = stall[1];
  assign rs_mult_exec_stall = stall[2];
  assign load_stall         = stall[3];
endmodule
